tfg_rx_buffer: RTL and testbench

Receive-side buffer for the twiddle-factor stream produced by the FOF twiddle-factor generator. The generator emits n twiddles per valid beat with no backpressure. This block captures one NTT frame of beats into a FIFO and replays them to the butterfly array under a valid/ready handshake, marking the last beat of the frame. It sits between the generator's `o_valid`/`o_tfg` outputs and the NTT datapath.

---
 rtl/tfg_rx_buffer.sv | 252 +++++++++++++++++++++++++
 tb/tb_tfg_rx_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tfg_rx_buffer.sv
// ---------------------------------------------------------------------------
// tfg_rx_buffer
//
// Receive-side buffer between the FOF twiddle-factor generator and the NTT
// butterfly array. The generator pushes one beat of n twiddles per cycle with
// no way to stall it; this block captures one NTT frame worth of beats into a
// first-word-fall-through FIFO and replays them downstream under valid/ready,
// flagging the final beat of the frame.
//
// Parameters
//   MAX_BW  bit width of one twiddle factor
//   n       twiddles (lanes) per beat, power of two, >= 2
//   DEPTH   FIFO depth in beats, power of two, >= 2
//
// Ports
//   clk        single rising-edge clock
//   rst_n      synchronous active-low reset
//   i_start    frame start pulse, latches i_log2N (honoured only when idle)
//   i_log2N    log2 of the NTT size for the frame
//   i_valid    generator beat valid (cannot be stalled)
//   i_tfg      generator beat, lane k at [k*MAX_BW +: MAX_BW]
//   o_valid    output beat valid (FIFO not empty)
//   i_ready    downstream ready
//   o_tfg      output beat (FIFO head), zero when empty
//   o_last     final beat of the frame is on o_tfg
//   o_beat     index of the current output beat within the frame
//   o_level    exact FIFO occupancy
//   o_busy     a frame is in progress
//   i_err_clr  clears the sticky error flags
//   o_err      sticky errors: [0] overflow drop, [1] start while busy,
//              [2] stray beat outside the receive phase
// ---------------------------------------------------------------------------
module tfg_rx_buffer #(
  parameter int MAX_BW = 62,
  parameter int n      = 16,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [3:0]                 i_log2N,
  input  logic                       i_valid,
  input  logic [n*MAX_BW-1:0]        i_tfg,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [n*MAX_BW-1:0]        o_tfg,
  output logic                       o_last,
  output logic [14:0]                o_beat,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_busy,
  input  logic                       i_err_clr,
  output logic [2:0]                 o_err
);

  localparam int WIDTH = n * MAX_BW;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [3:0]       LANE_BITS  = 4'($clog2(n));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Frame bookkeeping
  logic [14:0] beats_m1;
  logic [14:0] beats_m1_next;
  logic [3:0]  shift_amt;
  logic [14:0] wr_cnt;
  logic [14:0] rd_cnt;

  // FIFO storage and pointers
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  logic [2:0] err_q;

  // Per-cycle event decode
  logic has_data;
  logic fifo_full;
  logic hs;
  logic beat_in;
  logic wr_en;
  logic drop;
  logic start_ok;
  logic last_in;
  logic last_hs;
  logic [2:0] err_set;

  // Beat count for the requested NTT size, kept as B-1 so that the end-of-
  // frame tests are plain equality compares against the counters. Sizes at or
  // below one beat's worth of lanes still take a single beat.
  always_comb begin
    shift_amt = i_log2N - LANE_BITS;
    if (i_log2N > LANE_BITS) begin
      beats_m1_next = (15'd1 << shift_amt) - 15'd1;
    end else begin
      beats_m1_next = '0;
    end
  end

  // Event decode. A write into a full FIFO is still legal when the head is
  // leaving in the same cycle, which is what keeps back-to-back streaming at
  // full rate. Dropped beats still count as received so the frame boundary
  // on the input side never slips.
  always_comb begin
    has_data  = (level != '0);
    fifo_full = (level == FULL_LEVEL);
    hs        = has_data && i_ready;
    beat_in   = (state == RECV) && i_valid;
    wr_en     = beat_in && (!fifo_full || hs);
    drop      = beat_in && fifo_full && !hs;
    start_ok  = (state == IDLE) && i_start;
    last_in   = beat_in && (wr_cnt == beats_m1);
    last_hs   = hs && (rd_cnt == beats_m1);
    err_set   = {i_valid && (state != RECV),
                 i_start && (state != IDLE),
                 drop};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic. The final handshake takes priority over the final
  // write so that a frame whose last beat leaves while the FSM is still
  // receiving closes straight away instead of stalling in DRAIN.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_next = RECV;
        end
      end
      RECV: begin
        if (last_hs) begin
          state_next = IDLE;
        end else if (last_in) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM output decode plus the FIFO-facing outputs. The head entry is gated
  // with the non-empty flag so stale storage never shows on o_tfg after a
  // reset or a new frame start.
  always_comb begin
    o_busy  = (state != IDLE);
    o_valid = has_data;
    o_tfg   = has_data ? mem[rd_ptr] : '0;
    o_last  = has_data && (rd_cnt == beats_m1);
    o_beat  = rd_cnt;
    o_level = level;
    o_err   = err_q;
  end

  // Frame length register, loaded only when a start is actually accepted so
  // that a stray start cannot disturb the frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beats_m1 <= '0;
    end else if (start_ok) begin
      beats_m1 <= beats_m1_next;
    end
  end

  // Input and output beat counters, both restarted by an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (start_ok) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (beat_in) begin
        wr_cnt <= wr_cnt + 15'd1;
      end
      if (hs) begin
        rd_cnt <= rd_cnt + 15'd1;
      end
    end
  end

  // FIFO pointers and occupancy. Emptying is done by clearing the pointers and
  // level only; the storage array itself is never cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (start_ok) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (hs) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, hs})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage write port. No reset is needed: entries are only visible
  // through o_tfg once the level says they hold a valid beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_tfg;
    end
  end

  // Sticky error flags. The clear is applied first and new events are OR-ed
  // in afterwards, so an event in the same cycle as a clear is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= (i_err_clr ? 3'b000 : err_q) | err_set;
    end
  end

endmodule

// File: tb/tb_tfg_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_tfg_rx_buffer
//
// Directed bench for tfg_rx_buffer. A queue-based model of the frame buffer
// tracks what the outputs must be, and a negedge process compares every DUT
// output against it each cycle. Directed scenarios additionally pin key
// values with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_tfg_rx_buffer;

  localparam int MAX_BW = 62;
  localparam int LANES  = 16;
  localparam int DEPTH  = 16;
  localparam int W      = MAX_BW * LANES;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rstN;
  logic             start;
  logic [3:0]       log2N;
  logic             validIn;
  logic [W-1:0]     tfgIn;
  logic             readyIn;
  logic             errClr;
  logic             validOut;
  logic [W-1:0]     tfgOut;
  logic             lastOut;
  logic [14:0]      beatOut;
  logic [LVL_W-1:0] levelOut;
  logic             busyOut;
  logic [2:0]       errOut;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tfg_rx_buffer #(
    .MAX_BW (MAX_BW),
    .n      (LANES),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .i_start   (start),
    .i_log2N   (log2N),
    .i_valid   (validIn),
    .i_tfg     (tfgIn),
    .o_valid   (validOut),
    .i_ready   (readyIn),
    .o_tfg     (tfgOut),
    .o_last    (lastOut),
    .o_beat    (beatOut),
    .o_level   (levelOut),
    .o_busy    (busyOut),
    .i_err_clr (errClr),
    .o_err     (errOut)
  );

  // Lane k of beat j in frame 'tag'; tag 0 gives exactly j*16+k.
  function automatic logic [W-1:0] makeBeat(input int tag, input int j);
    logic [W-1:0] b;
    for (int k = 0; k < LANES; k++) begin
      b[k*MAX_BW +: MAX_BW] = MAX_BW'(tag * 4096 + j * 16 + k);
    end
    return b;
  endfunction

  function automatic int beatsFor(input int l2n);
    int laneBits;
    laneBits = $clog2(LANES);
    if (l2n > laneBits) begin
      return 1 << (l2n - laneBits);
    end
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  task automatic checkBeat(input string name, input logic [W-1:0] actual,
                           input logic [W-1:0] expected);
    int bad;
    compared++;
    if (actual !== expected) begin
      mismatched++;
      bad = 0;
      for (int k = LANES - 1; k >= 0; k--) begin
        if (actual[k*MAX_BW +: MAX_BW] !== expected[k*MAX_BW +: MAX_BW]) begin
          bad = k;
        end
      end
      $display("[TB] FAIL %s: lane %0d got 0x%0h, expected 0x%0h (t=%0t)",
               name, bad, actual[bad*MAX_BW +: MAX_BW],
               expected[bad*MAX_BW +: MAX_BW], $time);
    end
  endtask

  // Reference model: the FIFO is a queue of beats, a frame is "active" from
  // an accepted start until its B-th output handshake, and it is still
  // receiving while input beats of the frame remain outstanding.
  logic [W-1:0] mq[$];
  int           mB        = 1;
  int           mInLeft   = 0;
  int           mOutDone  = 0;
  bit           mActive   = 1'b0;
  logic [2:0]   mErr      = 3'b000;
  bit           modelReady = 1'b0;

  always @(posedge clk) begin
    int preSize;
    bit hsNow;
    bit recvNow;
    bit accept;
    logic [2:0] setBits;
    if (!rstN) begin
      mq.delete();
      mB         = 1;
      mInLeft    = 0;
      mOutDone   = 0;
      mActive    = 1'b0;
      mErr       = 3'b000;
      modelReady = 1'b1;
    end else if (modelReady) begin
      preSize = mq.size();
      hsNow   = (preSize != 0) && readyIn;
      recvNow = mActive && (mInLeft > 0);
      accept  = 1'b0;
      setBits = 3'b000;
      if (start && mActive) setBits[1] = 1'b1;
      if (validIn && !recvNow) setBits[2] = 1'b1;
      if (validIn && recvNow) begin
        accept = (preSize < DEPTH) || hsNow;
        if (!accept) setBits[0] = 1'b1;
        mInLeft--;
      end
      if (hsNow) begin
        void'(mq.pop_front());
        if (mActive && mOutDone == mB - 1) mActive = 1'b0;
        mOutDone++;
      end
      if (accept) mq.push_back(tfgIn);
      if (start && !setBits[1] && !mActive && !(hsNow && preSize == 0)) begin
        mq.delete();
        mB       = beatsFor(int'(log2N));
        mInLeft  = mB;
        mOutDone = 0;
        mActive  = 1'b1;
      end
      mErr = (errClr ? 3'b000 : mErr) | setBits;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    bit mValid;
    if (modelReady) begin
      mValid = (mq.size() != 0);
      checkOutput("model_valid", 64'(validOut), 64'(mValid));
      checkOutput("model_last", 64'(lastOut),
                  64'(mValid && (mOutDone == mB - 1)));
      checkOutput("model_beat", 64'(beatOut), 64'(15'(mOutDone)));
      checkOutput("model_level", 64'(levelOut), 64'(mq.size()));
      checkOutput("model_busy", 64'(busyOut), 64'(mActive));
      checkOutput("model_err", 64'(errOut), 64'(mErr));
      if (mValid) checkBeat("model_tfg", tfgOut, mq[0]);
    end
  end

  task automatic applyStimulus(input bit s, input logic [3:0] l, input bit v,
                               input logic [W-1:0] d, input bit r, input bit c);
    start   = s;
    log2N   = l;
    validIn = v;
    tfgIn   = d;
    readyIn = r;
    errClr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int count, input bit r);
    repeat (count) applyStimulus(1'b0, 4'd0, 1'b0, '0, r, 1'b0);
  endtask

  // Watchdog so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN    = 1'b0;
    start   = 1'b0;
    log2N   = 4'd0;
    validIn = 1'b0;
    tfgIn   = '0;
    readyIn = 1'b1;
    errClr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_valid", 64'(validOut), 64'(0));
    checkOutput("rst_last", 64'(lastOut), 64'(0));
    checkOutput("rst_busy", 64'(busyOut), 64'(0));
    checkOutput("rst_beat", 64'(beatOut), 64'(0));
    checkOutput("rst_level", 64'(levelOut), 64'(0));
    checkOutput("rst_err", 64'(errOut), 64'(0));
    checkBeat("rst_tfg", tfgOut, '0);
    rstN = 1'b1;
    idleCycles(1, 1'b1);

    // Basic frame, B=16, no stall: output j appears one cycle after input j
    applyStimulus(1'b1, 4'd8, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("basic_busy_after_start", 64'(busyOut), 64'(1));
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b0, 4'd8, 1'b1, makeBeat(0, j), 1'b1, 1'b0);
      checkOutput("basic_beat_idx", 64'(beatOut), 64'(j));
      checkOutput("basic_last", 64'(lastOut), 64'(j == 15));
      if (j == 2) checkOutput("basic_lane3_beat2",
                              64'(tfgOut[3*MAX_BW +: MAX_BW]), 64'(35));
    end
    idleCycles(1, 1'b1);
    checkOutput("basic_busy_done", 64'(busyOut), 64'(0));
    checkOutput("basic_valid_done", 64'(validOut), 64'(0));
    checkOutput("basic_err", 64'(errOut), 64'(0));

    // Small frame, B=1, plus a stray beat while draining
    applyStimulus(1'b1, 4'd3, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd3, 1'b1, makeBeat(1, 0), 1'b0, 1'b0);
    checkOutput("small_valid", 64'(validOut), 64'(1));
    checkOutput("small_last", 64'(lastOut), 64'(1));
    checkOutput("small_busy_drain", 64'(busyOut), 64'(1));
    applyStimulus(1'b0, 4'd3, 1'b1, makeBeat(1, 1), 1'b0, 1'b0);
    checkOutput("small_stray_err", 64'(errOut), 64'(3'b100));
    checkOutput("small_stray_level", 64'(levelOut), 64'(1));
    applyStimulus(1'b0, 4'd3, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("small_busy_done", 64'(busyOut), 64'(0));
    checkOutput("small_err_clr", 64'(errOut), 64'(0));

    // Full FIFO with simultaneous read, B=32
    applyStimulus(1'b1, 4'd9, 1'b0, '0, 1'b0, 1'b0);
    for (int j = 0; j < 16; j++)
      applyStimulus(1'b0, 4'd9, 1'b1, makeBeat(2, j), 1'b0, 1'b0);
    checkOutput("full_level", 64'(levelOut), 64'(16));
    for (int j = 16; j < 32; j++) begin
      applyStimulus(1'b0, 4'd9, 1'b1, makeBeat(2, j), 1'b1, 1'b0);
      checkOutput("full_rw_level", 64'(levelOut), 64'(16));
    end
    checkOutput("full_rw_err", 64'(errOut), 64'(0));
    checkBeat("full_rw_head", tfgOut, makeBeat(2, 16));
    idleCycles(16, 1'b1);
    checkOutput("full_busy_done", 64'(busyOut), 64'(0));
    checkOutput("full_beat_done", 64'(beatOut), 64'(32));

    // Overflow, B=32: 20 beats against a stalled sink lose beats 16..19.
    // Dropped beats still count on the input side, so only 28 beats ever
    // leave and the frame never reaches its last beat; reset abandons it.
    applyStimulus(1'b1, 4'd9, 1'b0, '0, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++)
      applyStimulus(1'b0, 4'd9, 1'b1, makeBeat(3, j), 1'b0, 1'b0);
    checkOutput("ovf_level", 64'(levelOut), 64'(16));
    checkOutput("ovf_err", 64'(errOut), 64'(3'b001));
    checkBeat("ovf_head", tfgOut, makeBeat(3, 0));
    for (int j = 20; j < 32; j++)
      applyStimulus(1'b0, 4'd9, 1'b1, makeBeat(3, j), 1'b1, 1'b0);
    idleCycles(20, 1'b1);
    checkOutput("ovf_beat_count", 64'(beatOut), 64'(28));
    checkOutput("ovf_busy_stuck", 64'(busyOut), 64'(1));
    checkOutput("ovf_no_last", 64'(lastOut), 64'(0));
    rstN = 1'b0;
    idleCycles(1, 1'b1);
    rstN = 1'b1;
    checkOutput("ovf_rst_busy", 64'(busyOut), 64'(0));
    checkOutput("ovf_rst_err", 64'(errOut), 64'(0));

    // Protocol errors: start mid-frame, stray beat in idle, clear priority
    applyStimulus(1'b1, 4'd8, 1'b0, '0, 1'b1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      applyStimulus(j == 4, 4'd8, 1'b1, makeBeat(4, j), 1'b1, 1'b0);
      if (j == 4) checkOutput("proto_start_err", 64'(errOut), 64'(3'b010));
    end
    idleCycles(1, 1'b1);
    checkOutput("proto_frame_done", 64'(beatOut), 64'(16));
    checkOutput("proto_busy_done", 64'(busyOut), 64'(0));
    applyStimulus(1'b0, 4'd8, 1'b1, makeBeat(9, 0), 1'b1, 1'b0);
    checkOutput("proto_stray_err", 64'(errOut), 64'(3'b110));
    checkOutput("proto_stray_valid", 64'(validOut), 64'(0));
    applyStimulus(1'b0, 4'd8, 1'b1, makeBeat(9, 1), 1'b1, 1'b1);
    checkOutput("proto_set_wins", 64'(errOut), 64'(3'b100));
    applyStimulus(1'b0, 4'd8, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("proto_clr", 64'(errOut), 64'(0));

    // Reset mid-frame, then a clean B=16 frame
    applyStimulus(1'b1, 4'd8, 1'b0, '0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++)
      applyStimulus(1'b0, 4'd8, 1'b1, makeBeat(5, j), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd8, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("mid_level", 64'(levelOut), 64'(5));
    checkOutput("mid_err", 64'(errOut), 64'(3'b010));
    rstN = 1'b0;
    idleCycles(1, 1'b0);
    rstN = 1'b1;
    checkOutput("mid_rst_valid", 64'(validOut), 64'(0));
    checkOutput("mid_rst_last", 64'(lastOut), 64'(0));
    checkOutput("mid_rst_busy", 64'(busyOut), 64'(0));
    checkOutput("mid_rst_beat", 64'(beatOut), 64'(0));
    checkOutput("mid_rst_level", 64'(levelOut), 64'(0));
    checkOutput("mid_rst_err", 64'(errOut), 64'(0));
    checkBeat("mid_rst_tfg", tfgOut, '0);
    idleCycles(1, 1'b1);
    checkOutput("mid_quiet_valid", 64'(validOut), 64'(0));
    applyStimulus(1'b1, 4'd8, 1'b0, '0, 1'b1, 1'b0);
    for (int j = 0; j < 16; j++)
      applyStimulus(1'b0, 4'd8, 1'b1, makeBeat(6, j), 1'b1, 1'b0);
    idleCycles(2, 1'b1);
    checkOutput("rerun_busy", 64'(busyOut), 64'(0));
    checkOutput("rerun_beat", 64'(beatOut), 64'(16));
    checkOutput("rerun_err", 64'(errOut), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
